regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
Sequences all writes into the 64-bit, 32-entry register file, which has a single write port. Two writeback requesters share that port under round-robin arbitration: the ALU result path and the memory load path. A per-register pending scoreboard tracks in-flight destinations and gates instruction issue on RAW and WAW hazards. An idle flag tells the ecall sequencer when every outstanding write has landed.

Parameters:
XLEN, 64, data width of register values
NREGS, 32, number of architectural registers
RIDX, 5, register index width (log2 NREGS)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
issue_valid  in  1  decode presents an instruction
issue_ready  out  1  instruction may issue this cycle
issue_rd  in  RIDX  destination register of issuing instruction
issue_rd_en  in  1  instruction writes a destination
issue_rs1  in  RIDX  source 1 index
issue_rs2  in  RIDX  source 2 index
alu_wb_valid  in  1  ALU result available
alu_wb_ready  out  1  ALU result accepted this cycle
alu_wb_rd  in  RIDX  ALU destination
alu_wb_data  in  XLEN  ALU result
mem_wb_valid  in  1  load result available
mem_wb_ready  out  1  load result accepted this cycle
mem_wb_rd  in  RIDX  load destination
mem_wb_data  in  XLEN  load result
rf_write_enable  out  1  register file write strobe
rf_write_register  out  RIDX  register file write index
rf_write_value  out  XLEN  register file write data
pending_count  out  RIDX+1  number of registers with pending writes
idle  out  1  no pending writes and no write in flight

Behaviour:
- Reset, synchronous: all pending bits 0; rf_write_enable 0; rf_write_register 0; rf_write_value 0; last-grant pointer set to MEM, so ALU wins the first conflict; pending_count 0; idle 1.
- Reset asserted mid-operation clears all state on that edge. Requests presented in the reset cycle are not accepted; both readies are 0 while reset is high.

Arbitration:
- Combinational grant. Only one requester valid: it is granted. Both valid: the requester not granted last time wins. The pointer updates only on an actual grant.
- The granted requester sees ready=1 in the same cycle. The transfer completes when valid and ready are both high. The loser's ready is 0, and it must hold its valid, rd and data stable.

Write stage:
- One-cycle latency. An accepted request drives rf_write_enable=1, rf_write_register and rf_write_value on the next cycle.
- The write stage is a pipeline register that accepts every cycle, so it never back-pressures.
- No accepted request: rf_write_enable=0, and register and value hold their previous values.
- rd=0: the request is accepted (ready=1) but rf_write_enable stays 0. x0 is never written.

Scoreboard:
- pending[r] is set on an issue handshake (issue_valid && issue_ready) when issue_rd_en=1 and issue_rd!=0.
- pending[r] is cleared in the cycle rf_write_enable=1 with rf_write_register=r.
- Set and clear of the same r in one cycle: set wins.
- pending[0] is permanently 0.
- issue_ready=0 if any of the following holds:
  - rs1 is pending and not being written this cycle, where "written this cycle" means rf_write_enable && rf_write_register==rs1. The register file forwards write_value, so the same-cycle write is safe.
  - Same condition for rs2.
  - issue_rd_en && issue_rd!=0 && pending[issue_rd] (WAW stall, even if the register is being cleared this cycle).
- Otherwise issue_ready=1. issue_ready is independent of issue_valid.
- pending_count is the registered popcount of pending, updated with the bits.
- idle = (pending==0) && !rf_write_enable.
- A writeback to a non-pending register is legal. The write still occurs, and nothing clears. A bench assertion flags it as a protocol warning only.

Test Plan:
- Reset, then issue rd=5 (rs1=0, rs2=0) → next cycle pending[5]=1, pending_count=1, idle=0. Then alu_wb rd=5 data=0xDEAD → ready same cycle; next cycle rf_write_enable=1, rf_write_register=5, rf_write_value=0xDEAD, pending[5] cleared the following cycle, idle=1.
- ALU and MEM both valid for 3 cycles with continuous new data (rd 6/7) → grants ALU, MEM, ALU. Each loser's ready=0 in its lost cycle, and rf writes appear in grant order one cycle later.
- pending[8]=1, issue with rs2=8 → issue_ready=0. The cycle rf_write_enable=1 with rf_write_register=8 → issue_ready=1 and the handshake completes.
- pending[9]=1, issue with rd=9 → issue_ready=0 including the write cycle for r9; issue_ready=1 the cycle after.
- mem_wb rd=0 data=0xFFFF → mem_wb_ready=1, rf_write_enable stays 0, pending unchanged.
- Three registers pending, reset asserted one cycle with an alu_wb valid → alu_wb_ready=0; after the edge pending_count=0, rf_write_enable=0, idle=1.

Source files
------------

// File: rtl/regfile_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler_if
// Description : Bundles the issue, ALU/MEM writeback, register-file write and
//               status signals of the register-file writeback scheduler.
//               The master side is the pipeline (decode and result producers)
//               and the slave side is the scheduler.
// Signals     : issue_*    decode issue handshake and operand indices
//               alu_wb_*   ALU result writeback handshake
//               mem_wb_*   load result writeback handshake
//               rf_write_* register-file write port
//               pending_count, idle  scoreboard status
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_scheduler_if #(
    parameter int XLEN = 64,
    parameter int RIDX = 5
);
    logic            issue_valid;
    logic            issue_ready;
    logic [RIDX-1:0] issue_rd;
    logic            issue_rd_en;
    logic [RIDX-1:0] issue_rs1;
    logic [RIDX-1:0] issue_rs2;

    logic            alu_wb_valid;
    logic            alu_wb_ready;
    logic [RIDX-1:0] alu_wb_rd;
    logic [XLEN-1:0] alu_wb_data;

    logic            mem_wb_valid;
    logic            mem_wb_ready;
    logic [RIDX-1:0] mem_wb_rd;
    logic [XLEN-1:0] mem_wb_data;

    logic            rf_write_enable;
    logic [RIDX-1:0] rf_write_register;
    logic [XLEN-1:0] rf_write_value;

    logic [RIDX:0]   pending_count;
    logic            idle;

    modport master (
        output issue_valid, issue_rd, issue_rd_en, issue_rs1, issue_rs2,
        input  issue_ready,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  alu_wb_ready,
        output mem_wb_valid, mem_wb_rd, mem_wb_data,
        input  mem_wb_ready,
        input  rf_write_enable, rf_write_register, rf_write_value,
        input  pending_count, idle
    );

    modport slave (
        input  issue_valid, issue_rd, issue_rd_en, issue_rs1, issue_rs2,
        output issue_ready,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        output alu_wb_ready,
        input  mem_wb_valid, mem_wb_rd, mem_wb_data,
        output mem_wb_ready,
        output rf_write_enable, rf_write_register, rf_write_value,
        output pending_count, idle
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Serialises ALU and load writebacks onto the single register
//               file write port with round-robin arbitration, and keeps a
//               per-register pending scoreboard that stalls issue on RAW and
//               WAW hazards.
// Ports       : clk     - clock
//               reset   - synchronous active-high reset
//               io_bus  - slave side of regfile_wb_scheduler_if (issue
//                         handshake, two writeback handshakes, register
//                         file write port, pending_count and idle status)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int RIDX  = 5
) (
    input  wire logic              clk,
    input  wire logic              reset,
    regfile_wb_scheduler_if.slave  io_bus
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NREGS-1:0] r_pending;
    logic             r_last_mem;      // 1: MEM held the port last time
    logic             r_wen;
    logic [RIDX-1:0]  r_wreg;
    logic [XLEN-1:0]  r_wval;
    logic [RIDX:0]    r_pcount;

    // ------------------------------------------------------------------------
    // Round-robin grant. Both requesters are masked while reset is high so
    // nothing is accepted in the reset cycle.
    // ------------------------------------------------------------------------
    logic w_alu_gnt;
    logic w_mem_gnt;

    assign w_alu_gnt = !reset && io_bus.alu_wb_valid &&
                       (!io_bus.mem_wb_valid || r_last_mem);
    assign w_mem_gnt = !reset && io_bus.mem_wb_valid &&
                       (!io_bus.alu_wb_valid || !r_last_mem);

    assign io_bus.alu_wb_ready = w_alu_gnt;
    assign io_bus.mem_wb_ready = w_mem_gnt;

    // Selected writeback for the write-stage register
    logic [RIDX-1:0] w_sel_rd;
    logic [XLEN-1:0] w_sel_data;

    assign w_sel_rd   = w_alu_gnt ? io_bus.alu_wb_rd   : io_bus.mem_wb_rd;
    assign w_sel_data = w_alu_gnt ? io_bus.alu_wb_data : io_bus.mem_wb_data;

    // ------------------------------------------------------------------------
    // Issue hazard check. A source being written this cycle is not a hazard
    // because the register file forwards the write data. A WAW stall holds
    // even during the clearing write so the new set never collides with it.
    // ------------------------------------------------------------------------
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_waw_hit;
    logic w_issue_ready;
    logic w_issue_fire;

    assign w_rs1_hit = r_pending[io_bus.issue_rs1] &&
                       !(r_wen && (r_wreg == io_bus.issue_rs1));
    assign w_rs2_hit = r_pending[io_bus.issue_rs2] &&
                       !(r_wen && (r_wreg == io_bus.issue_rs2));
    assign w_waw_hit = io_bus.issue_rd_en && (io_bus.issue_rd != '0) &&
                       r_pending[io_bus.issue_rd];

    assign w_issue_ready = !(w_rs1_hit || w_rs2_hit || w_waw_hit);
    assign w_issue_fire  = io_bus.issue_valid && w_issue_ready;

    assign io_bus.issue_ready = w_issue_ready;

    // ------------------------------------------------------------------------
    // Next scoreboard: clear first, then set, so a same-cycle set wins.
    // ------------------------------------------------------------------------
    logic [NREGS-1:0] w_pending_next;
    logic [RIDX:0]    w_count_next;

    always_comb begin
        w_pending_next = r_pending;
        if (r_wen) begin
            w_pending_next[r_wreg] = 1'b0;
        end
        if (w_issue_fire && io_bus.issue_rd_en && (io_bus.issue_rd != '0)) begin
            w_pending_next[io_bus.issue_rd] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_count_next = w_count_next + {{RIDX{1'b0}}, w_pending_next[i]};
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_last_mem <= 1'b1;
            r_wen      <= 1'b0;
            r_wreg     <= '0;
            r_wval     <= '0;
            r_pcount   <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_pcount  <= w_count_next;

            if (w_alu_gnt) begin
                r_last_mem <= 1'b0;
            end else if (w_mem_gnt) begin
                r_last_mem <= 1'b1;
            end

            // x0 writes are consumed but never reach the register file;
            // index and value keep their previous contents in that case.
            if ((w_alu_gnt || w_mem_gnt) && (w_sel_rd != '0)) begin
                r_wen  <= 1'b1;
                r_wreg <= w_sel_rd;
                r_wval <= w_sel_data;
            end else begin
                r_wen  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign io_bus.rf_write_enable   = r_wen;
    assign io_bus.rf_write_register = r_wreg;
    assign io_bus.rf_write_value    = r_wval;
    assign io_bus.pending_count     = r_pcount;
    assign io_bus.idle              = (r_pending == '0) && !r_wen;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_scheduler
// Description : Directed self-checking bench for regfile_wb_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    regfile_wb_scheduler_if #(.XLEN(64), .RIDX(5)) bus ();

    regfile_wb_scheduler #(.XLEN(64), .NREGS(32), .RIDX(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side view of which destinations are in flight, used only to
    // flag writebacks to registers nobody issued.
    logic [31:0] tb_pending;
    always @(posedge clk) begin
        if (reset) begin
            tb_pending <= '0;
        end else begin
            if (bus.rf_write_enable) begin
                if (!tb_pending[bus.rf_write_register])
                    $display("protocol warning: writeback to non-pending x%0d",
                             bus.rf_write_register);
                tb_pending[bus.rf_write_register] <= 1'b0;
            end
            if (bus.issue_valid && bus.issue_ready && bus.issue_rd_en &&
                bus.issue_rd != 5'd0)
                tb_pending[bus.issue_rd] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.issue_valid  = 1'b0;
        bus.issue_rd     = '0;
        bus.issue_rd_en  = 1'b0;
        bus.issue_rs1    = '0;
        bus.issue_rs2    = '0;
        bus.alu_wb_valid = 1'b0;
        bus.alu_wb_rd    = '0;
        bus.alu_wb_data  = '0;
        bus.mem_wb_valid = 1'b0;
        bus.mem_wb_rd    = '0;
        bus.mem_wb_data  = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_we",    bus.rf_write_enable,   0);
        chk("rst_reg",   bus.rf_write_register, 0);
        chk("rst_val",   bus.rf_write_value,    0);
        chk("rst_cnt",   bus.pending_count,     0);
        chk("rst_idle",  bus.idle,              1);
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd3; bus.alu_wb_data = 64'h1;
        #1;
        chk("rst_alu_rdy", bus.alu_wb_ready, 0);
        tick();
        bus.alu_wb_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_noacc_we", bus.rf_write_enable, 0);

        // ---------------- issue rd=5 then ALU writeback ----------------
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.issue_rd_en = 1'b1;
        bus.issue_rs1 = 5'd0; bus.issue_rs2 = 5'd0;
        #1;
        chk("t1_issue_rdy", bus.issue_ready, 1);
        tick();
        bus.issue_valid = 1'b0;
        chk("t1_cnt1",  bus.pending_count, 1);
        chk("t1_idle0", bus.idle, 0);
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd5; bus.alu_wb_data = 64'hDEAD;
        #1;
        chk("t1_alu_rdy", bus.alu_wb_ready, 1);
        chk("t1_mem_rdy", bus.mem_wb_ready, 0);
        tick();
        bus.alu_wb_valid = 1'b0;
        chk("t1_we",    bus.rf_write_enable,   1);
        chk("t1_reg",   bus.rf_write_register, 5);
        chk("t1_val",   bus.rf_write_value,    64'hDEAD);
        chk("t1_cnt_still", bus.pending_count, 1);
        chk("t1_idle_wr",   bus.idle, 0);
        tick();
        chk("t1_cnt0",  bus.pending_count, 0);
        chk("t1_idle1", bus.idle, 1);
        chk("t1_we0",   bus.rf_write_enable, 0);
        chk("t1_reg_hold", bus.rf_write_register, 5);
        chk("t1_val_hold", bus.rf_write_value, 64'hDEAD);

        // ---------------- MEM writeback to x0 ----------------
        bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 5'd0; bus.mem_wb_data = 64'hFFFF;
        #1;
        chk("t5_mem_rdy", bus.mem_wb_ready, 1);
        tick();
        bus.mem_wb_valid = 1'b0;
        chk("t5_we0",  bus.rf_write_enable, 0);
        chk("t5_reg",  bus.rf_write_register, 5);
        chk("t5_cnt",  bus.pending_count, 0);
        chk("t5_idle", bus.idle, 1);

        // ---------------- ALU/MEM conflict for 3 cycles ----------------
        // MEM was granted last, so ALU wins first.
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd6; bus.alu_wb_data = 64'h61;
        bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 5'd7; bus.mem_wb_data = 64'h71;
        #1;
        chk("t2_c0_alu_rdy", bus.alu_wb_ready, 1);
        chk("t2_c0_mem_rdy", bus.mem_wb_ready, 0);
        tick();
        bus.alu_wb_data = 64'h62;
        #1;
        chk("t2_c1_alu_rdy", bus.alu_wb_ready, 0);
        chk("t2_c1_mem_rdy", bus.mem_wb_ready, 1);
        chk("t2_w0_we",  bus.rf_write_enable,   1);
        chk("t2_w0_reg", bus.rf_write_register, 6);
        chk("t2_w0_val", bus.rf_write_value,    64'h61);
        tick();
        bus.mem_wb_data = 64'h72;
        #1;
        chk("t2_c2_alu_rdy", bus.alu_wb_ready, 1);
        chk("t2_c2_mem_rdy", bus.mem_wb_ready, 0);
        chk("t2_w1_reg", bus.rf_write_register, 7);
        chk("t2_w1_val", bus.rf_write_value,    64'h71);
        tick();
        bus.alu_wb_valid = 1'b0;
        bus.mem_wb_valid = 1'b0;
        chk("t2_w2_we",  bus.rf_write_enable,   1);
        chk("t2_w2_reg", bus.rf_write_register, 6);
        chk("t2_w2_val", bus.rf_write_value,    64'h62);
        tick();
        chk("t2_we0", bus.rf_write_enable, 0);

        // ---------------- RAW stall on rs2=8 ----------------
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd8; bus.issue_rd_en = 1'b1;
        bus.issue_rs1 = 5'd0; bus.issue_rs2 = 5'd0;
        tick();
        bus.issue_rd = 5'd0; bus.issue_rd_en = 1'b0; bus.issue_rs2 = 5'd8;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd8; bus.alu_wb_data = 64'h88;
        #1;
        chk("t3_cnt1",      bus.pending_count, 1);
        chk("t3_raw_stall", bus.issue_ready, 0);
        chk("t3_alu_rdy",   bus.alu_wb_ready, 1);
        tick();
        bus.alu_wb_valid = 1'b0;
        #1;
        chk("t3_fwd_we",  bus.rf_write_enable,   1);
        chk("t3_fwd_rdy", bus.issue_ready, 1);
        tick();
        bus.issue_valid = 1'b0;
        chk("t3_cnt0", bus.pending_count, 0);

        // ---------------- WAW stall on rd=9 ----------------
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.issue_rd_en = 1'b1;
        bus.issue_rs1 = 5'd0; bus.issue_rs2 = 5'd0;
        tick();
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd9; bus.alu_wb_data = 64'h99;
        #1;
        chk("t4_waw_stall", bus.issue_ready, 0);
        tick();
        bus.alu_wb_valid = 1'b0;
        #1;
        chk("t4_wr_reg9",   bus.rf_write_register, 9);
        chk("t4_waw_wrcyc", bus.issue_ready, 0);
        tick();
        chk("t4_rdy_after", bus.issue_ready, 1);
        chk("t4_cnt0",      bus.pending_count, 0);
        tick();
        chk("t4_cnt1",      bus.pending_count, 1);

        // ---------------- reset mid-operation ----------------
        bus.issue_rd = 5'd10;
        tick();
        bus.issue_rd = 5'd11;
        tick();
        bus.issue_valid = 1'b0;
        chk("t6_cnt3", bus.pending_count, 3);
        reset = 1'b1;
        bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd10; bus.alu_wb_data = 64'hAA;
        #1;
        chk("t6_alu_rdy", bus.alu_wb_ready, 0);
        tick();
        reset = 1'b0;
        bus.alu_wb_valid = 1'b0;
        chk("t6_cnt0", bus.pending_count, 0);
        chk("t6_we0",  bus.rf_write_enable, 0);
        chk("t6_idle", bus.idle, 1);
        chk("t6_reg0", bus.rf_write_register, 0);
        tick();
        chk("t6_we_after", bus.rf_write_enable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
